// File: rtl/fb_scan_reader.sv
// Framebuffer scan-out reader: loads one bitmap line per blanking
// interval into a line buffer and replays it SCALE x SCALE.
module fb_scan_reader #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int CIDXW     = 4,
  parameter int SCALE     = 4,
  parameter int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             line,
  input  logic             de,
  output logic             fb_re,
  output logic [ADDRW-1:0] fb_addr,
  input  logic [CIDXW-1:0] fb_data,
  output logic [CIDXW-1:0] cidx,
  output logic             paint,
  output logic             underrun
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int YW = $clog2(FB_HEIGHT + 1);
  localparam int PW = $clog2(FB_WIDTH + 1);
  localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;

  localparam logic [SW-1:0]    SUB_LAST = SW'(SCALE - 1);
  localparam logic [YW-1:0]    Y_END    = YW'(FB_HEIGHT);
  localparam logic [PW-1:0]    X_END    = PW'(FB_WIDTH);
  localparam logic [PW-1:0]    X_LAST   = PW'(FB_WIDTH - 1);
  localparam logic [ADDRW-1:0] STRIDE   = ADDRW'(FB_WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, ACTIVE} state_t;

  state_t           state;
  logic [SW-1:0]    ln_sub;
  logic [SW-1:0]    px_sub;
  logic [YW-1:0]    fb_y;
  logic [ADDRW-1:0] base;
  logic [PW-1:0]    ld_cnt;
  logic [PW-1:0]    px;
  logic             rd_v;
  logic [XW-1:0]    wr_idx;
  logic             de_q;
  logic             bad_line;
  logic [CIDXW-1:0] lbuf [FB_WIDTH];

  logic             rise;
  logic             fall;
  logic [PW-1:0]    px_e;
  logic [SW-1:0]    sub_e;
  logic             show;
  logic [CIDXW-1:0] pix;

  always_comb begin
    rise  = de & ~de_q;
    fall  = ~de & de_q;
    px_e  = rise ? '0 : px;
    sub_e = rise ? '0 : px_sub;
    pix   = lbuf[px_e[XW-1:0]];
    // a stale underrun flag must not blank the first pixel of the next line
    show  = (state == ACTIVE) && !(bad_line && !rise) &&
            (px_e < X_END) && (fb_y < Y_END);
  end

  always_ff @(posedge clk) begin
    if (rd_v) lbuf[wr_idx] <= fb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ln_sub   <= '0;
      px_sub   <= '0;
      fb_y     <= '0;
      base     <= '0;
      ld_cnt   <= '0;
      px       <= '0;
      rd_v     <= 1'b0;
      wr_idx   <= '0;
      de_q     <= 1'b0;
      bad_line <= 1'b0;
      fb_re    <= 1'b0;
      fb_addr  <= '0;
      cidx     <= '0;
      paint    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      de_q   <= de;
      paint  <= de;
      rd_v   <= fb_re;
      wr_idx <= ld_cnt[XW-1:0];
      cidx   <= show ? pix : '0;

      if (de) begin
        if (sub_e == SUB_LAST) begin
          px_sub <= '0;
          px     <= (px_e == X_END) ? px_e : px_e + 1'b1;
        end else begin
          px_sub <= sub_e + 1'b1;
          px     <= px_e;
        end
      end

      if (rise) bad_line <= (state == LOAD);
      if (rise && state == LOAD) underrun <= 1'b1;

      if (frame) begin
        ln_sub <= '0;
        fb_y   <= '0;
        base   <= '0;
        fb_re  <= 1'b0;
        state  <= WAIT;
        if (line) begin
          state   <= LOAD;
          fb_re   <= 1'b1;
          fb_addr <= '0;
          ld_cnt  <= '0;
        end
      end else begin
        unique case (state)
          IDLE: ;
          WAIT, ACTIVE: begin
            if (state == ACTIVE && fall) begin
              if (ln_sub == SUB_LAST) begin
                ln_sub <= '0;
                if (fb_y != Y_END) begin
                  fb_y <= fb_y + 1'b1;
                  base <= base + STRIDE;
                end
              end else begin
                ln_sub <= ln_sub + 1'b1;
              end
            end
            if (line) begin
              if (ln_sub == '0 && fb_y < Y_END) begin
                state   <= LOAD;
                fb_re   <= 1'b1;
                fb_addr <= base;
                ld_cnt  <= '0;
              end else begin
                state <= ACTIVE;
              end
            end
          end
          LOAD: begin
            // one trailing cycle lets the last read land in the buffer
            if (fb_re) begin
              ld_cnt  <= ld_cnt + 1'b1;
              fb_addr <= fb_addr + 1'b1;
              if (ld_cnt == X_LAST) fb_re <= 1'b0;
            end else begin
              state <= ACTIVE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Scoreboard bench for fb_scan_reader on a reduced 16x6 bitmap,
// SCALE=4, with a behavioural framebuffer memory.
module tb_fb_scan_reader;

  localparam int W  = 16;
  localparam int H  = 6;
  localparam int S  = 4;
  localparam int CW = 4;
  localparam int AW = $clog2(W*H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame = 1'b0;
  logic          line = 1'b0;
  logic          de = 1'b0;
  logic          fb_re;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_data = '0;
  logic [CW-1:0] cidx;
  logic          paint;
  logic          underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int pix_q[$];
  int addr_q[$];
  bit mon_on = 1'b0;
  logic de_last = 1'b0;
  logic re_last = 1'b0;
  int loads = 0;
  int last_start = -1;

  always #5 clk = ~clk;

  fb_scan_reader #(
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .CIDXW    (CW),
    .SCALE    (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .frame   (frame),
    .line    (line),
    .de      (de),
    .fb_re   (fb_re),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .cidx    (cidx),
    .paint   (paint),
    .underrun(underrun)
  );

  function automatic int memv(int a);
    if (a == 2*W + 5) return 'hA;
    return (a*7 + a/5) % 16;
  endfunction

  function automatic int exp_pix(int dl, int j, bit live, bit bad);
    int y;
    int x;
    if (!live || bad) return 0;
    y = dl / S;
    x = j / S;
    if (y >= H) return 0;
    return memv(y*W + x);
  endfunction

  always @(posedge clk) fb_data <= fb_re ? CW'(memv(int'(fb_addr))) : '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("paint", 32'(paint), 32'(de_last));
      de_last = de;
      if (paint) begin
        if (pix_q.size() == 0) check("paint_unexp", 32'(paint), 0);
        else check("cidx", 32'(cidx), pix_q.pop_front());
      end
      if (fb_re) begin
        if (!re_last) begin
          loads++;
          last_start = int'(fb_addr);
        end
        if (addr_q.size() == 0) check("rd_unexp", 32'(fb_re), 0);
        else check("fb_addr", 32'(fb_addr), addr_q.pop_front());
      end
      re_last = fb_re;
    end
  end

  task automatic run_line(int dl, int gap, bit live, bit bad, bit wf);
    bit ld;
    ld = live && (dl % S == 0) && (dl / S < H);
    if (wf) frame = 1'b1;
    line = 1'b1;
    if (ld) for (int k = 0; k < W; k++) addr_q.push_back((dl/S)*W + k);
    tick();
    frame = 1'b0;
    line = 1'b0;
    repeat (gap - 1) tick();
    for (int j = 0; j < W*S; j++) begin
      de = 1'b1;
      pix_q.push_back(exp_pix(dl, j, live, bad));
      tick();
    end
    de = 1'b0;
    repeat (6) tick();
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_fb_re", 32'(fb_re), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_cidx", 32'(cidx), 0);
    check("rst_paint", 32'(paint), 0);
    check("rst_underrun", 32'(underrun), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    run_line(0, W + 4, 1'b0, 1'b0, 1'b0);

    pulse_frame();
    loads = 0;
    for (int dl = 0; dl <= H*S; dl++) run_line(dl, W + 4, 1'b1, 1'b0, 1'b0);
    check("loads", 32'(loads), 32'(H));
    check("last_load", 32'(last_start), 32'((H-1)*W));
    check("no_underrun", 32'(underrun), 0);

    run_line(0, W + 4, 1'b1, 1'b0, 1'b1);
    for (int dl = 1; dl < 4; dl++) run_line(dl, W + 4, 1'b1, 1'b0, 1'b0);
    run_line(4, 10, 1'b1, 1'b1, 1'b0);
    check("underrun_set", 32'(underrun), 1);
    run_line(5, W + 4, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    check("underrun_sticky", 32'(underrun), 1);
    run_line(0, W + 4, 1'b1, 1'b0, 1'b0);

    pulse_frame();
    line = 1'b1;
    for (int k = 0; k < 6; k++) addr_q.push_back(k);
    tick();
    line = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_fb_re", 32'(fb_re), 0);
    check("mrst_fb_addr", 32'(fb_addr), 0);
    check("mrst_cidx", 32'(cidx), 0);
    check("mrst_paint", 32'(paint), 0);
    check("mrst_underrun", 32'(underrun), 0);
    tick();
    run_line(0, W + 4, 1'b0, 1'b0, 1'b0);
    pulse_frame();
    run_line(0, W + 4, 1'b1, 1'b0, 1'b0);

    check("pix_left", 32'(pix_q.size()), 0);
    check("addr_left", 32'(addr_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_scan_reader.md
# fb_scan_reader

Framebuffer scan-out reader for the 320x180, 4-bit colour-index bitmap that the shape renderers draw into. It consumes display timing strobes and reads one bitmap line into an internal line buffer during horizontal blanking. It then replays that line SCALE times horizontally and vertically, emitting one colour index per display pixel with fixed latency. It sits between the framebuffer memory read port and the palette lookup / display output stage.

## Interface
- FB_WIDTH, 320, bitmap width in pixels
- FB_HEIGHT, 180, bitmap height in lines
- CIDXW, 4, colour index width (bits)
- SCALE, 4, integer up-scale factor, ≥1 (1=320x180, 2=640x360, 4=1280x720)
- ADDRW, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer address width (16 at defaults)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame  in  1  single-cycle pulse; start of frame, before the first line pulse
- line  in  1  single-cycle pulse; start of each display line, at least FB_WIDTH+2 cycles before that line's first de
- de  in  1  display enable; high for active pixels of the current line
- fb_re  out  1  framebuffer read enable
- fb_addr  out  ADDRW  framebuffer read address
- fb_data  in  CIDXW  read data; valid exactly one cycle after fb_re
- cidx  out  CIDXW  colour index for the display pixel
- paint  out  1  cidx valid: de delayed one cycle
- underrun  out  1  sticky; set when de rises while a line load is in progress

## Operation
- State machine: IDLE, WAIT, LOAD, ACTIVE.
  - IDLE: entered on reset; no reads; cidx=0. frame -> WAIT.
  - WAIT: waiting for a line pulse.
  - LOAD: issues FB_WIDTH reads, then returns to ACTIVE.
  - ACTIVE: replays the line buffer while de is high.
- Counters:
  - ln_sub counts 0..SCALE-1 within a bitmap line.
  - fb_y counts 0..FB_HEIGHT.
  - base is the line base address, advanced by FB_WIDTH per bitmap line, no multiplier.
- frame (any state except IDLE-with-rst): clears ln_sub, fb_y, base; aborts any LOAD; -> WAIT. underrun is not cleared.
- line pulse in WAIT/ACTIVE:
  - If ln_sub==0 and fb_y<FB_HEIGHT: -> LOAD.
  - Else: -> ACTIVE, reusing the buffer.
  - If fb_y==FB_HEIGHT: -> ACTIVE with blank output.
- LOAD:
  - Cycle k (0..FB_WIDTH-1): fb_re=1, fb_addr=base+k.
  - fb_data for k is written to lbuf[k] on cycle k+1.
  - After the final write (FB_WIDTH+1 cycles after entry), -> ACTIVE.
- Line end (falling edge of de, in ACTIVE):
  - ln_sub increments.
  - At SCALE-1, ln_sub wraps to 0, fb_y increments (saturating at FB_HEIGHT) and base+=FB_WIDTH.
- Horizontal replay:
  - On the rising edge of de, px_sub=0 and px=0.
  - Each de cycle, px_sub increments; at SCALE-1 it wraps and px increments.
  - px saturates at FB_WIDTH.
  - Output is lbuf[px] when px<FB_WIDTH and fb_y<FB_HEIGHT, else 0.
- A line pulse with no de in between still counts as a line only if de occurred; line counting is driven by the de falling edge.
- de rising while in LOAD:
  - underrun<=1.
  - Output is 0 for that line.
  - The load completes normally.
- Before the first frame after reset: fb_re=0, cidx=0, paint follows de.

## Timing
- Reset values: fb_re=0, fb_addr=0, cidx=0, paint=0, underrun=0, state=IDLE, all counters 0.
- Pixel latency is 1 cycle: cidx/paint at cycle t+1 correspond to de at cycle t. cidx is registered.
- Load latency: FB_WIDTH+1 cycles from the line pulse to ACTIVE (321 at default).
- fb_re is never asserted outside LOAD; there are no reads during de.
- frame and line in the same cycle: frame takes effect first, then the line is handled as the first line of the frame (LOAD of line 0).
- rst mid-LOAD: fb_re drops on the next cycle, state returns to IDLE, and the buffer contents are don't-care.

## Test plan
- Reset, then frame, then line with 330 cycles of blanking: fb_re high for 320 cycles, fb_addr 0..319; no underrun.
- Bitmap pixel (x=5, y=2) holds 0xA, SCALE=4: display lines 8..11, de cycles 20..23 -> cidx=0xA (one cycle later); neighbours match the bitmap; paint mirrors de delayed 1.
- Full frame of 720 display lines: exactly 180 loads; the addresses of load n start at n*320; the last load starts at 57280.
- A 721st display line with de: no load, cidx=0 throughout, paint=1.
- de rising 100 cycles after line during a load: underrun=1 and stays 1 after the next frame; cidx=0 for that line; the next line is correct.
- rst asserted at LOAD cycle 50: fb_re=0 next cycle; all outputs at reset values; no reads until the next frame.
